cordic_sincos: RTL and testbench
================================

Name: cordic_sincos

Overview:
- Iterative CORDIC rotation engine returning both sine and cosine of a signed fixed-point angle (radians).
- Parametrised successor to the single-output Q16.16 cosine block: generic width, fractional bits and iteration count, both outputs from one run.
- Explicit start/busy/done handshake and out-of-range error flag.
- Sits in the basic math library beside the fixed-point add, multiply, divide and sqrt blocks; consumed by the rotation and phase logic.

Parameters:
- W, 32, total signed word width of angle and results (two's complement).
- FRAC, 16, fractional bits (Q(W-FRAC).FRAC); legal range 8..W-3.
- ITER, 16, CORDIC micro-rotations; legal range 4..FRAC.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- angle  in  W  signed radians, QFRAC; legal range [-pi, +pi].
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse when sin_out/cos_out/err update.
- err  out  1  angle was out of range on the last accepted request; held until next acceptance.
- sin_out  out  W  signed QFRAC sine; held until next done.
- cos_out  out  W  signed QFRAC cosine; held until next done.

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. On reset busy=0, done=0, err=0, sin_out=0, cos_out=0, FSM=IDLE, all datapath registers 0.
- FSM states:
  - IDLE: start=1 captures angle -> LOAD.
  - LOAD (1 cycle): range check and quadrant fold.
    - If out of range -> OUT with err=1, sin=cos=0.
    - Otherwise x=K, y=0, z=folded angle, i=0 -> ROT.
  - ROT: one micro-rotation per cycle; i=ITER-1 -> OUT.
  - OUT (1 cycle): saturate, apply fold sign, register outputs, pulse done -> IDLE.
- Latency: done asserts ITER+2 cycles after the start-accept edge (18 at defaults). Error path: done 2 cycles after acceptance.
- Back-to-back: start in the cycle done is high is ignored; start is accepted the following cycle in IDLE.
- start while busy=1 is ignored; no queuing, no effect on the run in progress. angle is sampled only on the accept edge.
- Range: PI = round(pi*2^FRAC). Out of range when angle > PI or angle < -PI.
- Fold:
  - angle > PI/2: z = angle - PI, negate both results.
  - angle < -PI/2: z = angle + PI, negate both results.
  - Otherwise no fold.
- Iteration i, with d = +1 if z >= 0 else -1:
  - x' = x - d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*ATAN[i]
  - All three use old values; arithmetic shift.
- Internal x/y/z width W+2 (guard bits). K = round(0.6072529350*2^FRAC), pre-scaled so no post-multiply is needed.
- Output: truncate to W, then saturate to [-(1<<FRAC), +(1<<FRAC)].
- Accuracy: |error| <= 4 LSB for ITER=FRAC=16.
- Reset asserted mid-run: immediate return to IDLE, all outputs cleared, no done pulse.

Decomposition:
- Package cordic_pkg: ATAN table generator (round(atan(2^-i)*2^FRAC) for i=0..ITER-1), K, PI, PI_HALF constants as FRAC-parametrised functions, and FSM state encoding.
- Sub-module cordic_atan_lut: combinational index -> ATAN[i], width W+2.
- Top holds the FSM, iteration counter and datapath.

Test Plan:
- Reset, then angle=0x0000_0000 -> done at cycle 18, cos_out=0x0001_0000 ±4, sin_out=0 ±4, err=0.
- angle=0x0000_860A (pi/6) -> sin_out=0x0000_8000 ±4, cos_out=0x0000_DDB4 ±4.
- angle=0x0001_921F (pi/2) and 0xFFFE_6DE1 (-pi/2) -> sin_out=0x0001_0000 / 0xFFFF_0000 ±4, cos_out≈0. angle=0x0003_243F (pi) -> cos_out=0xFFFF_0000 ±4 (fold path), no value exceeds ±0x0001_0000.
- angle=0x0004_0000 (4.0) -> done 2 cycles after accept, err=1, sin_out=cos_out=0; next legal request clears err.
- start pulsed at cycles 5 and 10 of a run with different angles -> ignored, results match the first angle. Start in the done cycle -> ignored; start one cycle later -> accepted.
- rst_n low at cycle 8 of a run -> busy=0, outputs 0, no done pulse; new start after release completes normally in 18 cycles.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the iterative CORDIC sine/cosine engine.
// Reference values are held at 2^-32 resolution and rounded to the requested FRAC.
package cordic_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StRot, StOut} cordic_state_e;

    function automatic longint scale_round(input longint v, input int unsigned frac);
        if (frac >= 32) begin
            return v <<< (frac - 32);
        end
        return (v + (longint'(1) <<< (31 - frac))) >>> (32 - frac);
    endfunction

    // round(atan(2^-i) * 2^32); beyond i=11 the cubic term is below half an LSB.
    function automatic longint atan_val(input int unsigned i, input int unsigned frac);
        longint v;
        case (i)
            0:  v = 64'sd3373259426;
            1:  v = 64'sd1991351318;
            2:  v = 64'sd1052175346;
            3:  v = 64'sd534100635;
            4:  v = 64'sd268086748;
            5:  v = 64'sd134174063;
            6:  v = 64'sd67103403;
            7:  v = 64'sd33553749;
            8:  v = 64'sd16777131;
            9:  v = 64'sd8388597;
            10: v = 64'sd4194303;
            default: v = (i < 32) ? (longint'(1) <<< (32 - i)) : longint'(0);
        endcase
        return scale_round(v, frac);
    endfunction

    function automatic longint k_val(input int unsigned frac);
        return scale_round(64'sd2608131496, frac);
    endfunction

    function automatic longint pi_val(input int unsigned frac);
        return scale_round(64'sd13493037705, frac);
    endfunction

    function automatic longint pi_half_val(input int unsigned frac);
        return scale_round(64'sd6746518852, frac);
    endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent table: idx -> round(atan(2^-idx) * 2^FRAC), W+2 bits wide.
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = 16,
    parameter int unsigned ITER = 16,
    localparam int unsigned IW  = $clog2(ITER)
) (
    input  logic [IW-1:0]       idx,
    output logic signed [W+1:0] atan
);

    logic signed [W+1:0] rom [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_rom
        assign rom[g] = (W+2)'(atan_val(g, FRAC));
    end

    assign atan = rom[idx];

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC rotation: one micro-rotation per cycle, sine and cosine from one run,
// quadrant fold into [-pi/2, pi/2] and range error for |angle| > pi.
module cordic_sincos
    import cordic_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = 16,
    parameter int unsigned ITER = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] angle,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic signed [W-1:0] sin_out,
    output logic signed [W-1:0] cos_out
);

    localparam int unsigned IW = $clog2(ITER);
    localparam int unsigned XW = W + 2;
    localparam logic signed [XW-1:0] KVal   = XW'(k_val(FRAC));
    localparam logic signed [XW-1:0] PiVal  = XW'(pi_val(FRAC));
    localparam logic signed [XW-1:0] PiHalf = XW'(pi_half_val(FRAC));
    localparam logic signed [W-1:0]  One    = W'(longint'(1) <<< FRAC);
    localparam logic [IW-1:0]        LastIdx = IW'(ITER - 1);

    cordic_state_e        state;
    logic signed [W-1:0]  angle_q;
    logic signed [XW-1:0] x, y, z;
    logic [IW-1:0]        idx;
    logic                 negate;
    logic                 range_err;

    logic signed [XW-1:0] atan_i, angle_ext, x_shr, y_shr, x_nxt, y_nxt, z_nxt;
    logic signed [W-1:0]  cos_sat, sin_sat;

    function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] t);
        if (t > One) return One;
        if (t < -One) return -One;
        return t;
    endfunction

    cordic_atan_lut #(
        .W   (W),
        .FRAC(FRAC),
        .ITER(ITER)
    ) u_lut (
        .idx (idx),
        .atan(atan_i)
    );

    always_comb begin
        angle_ext = XW'(angle_q);
        x_shr     = x >>> idx;
        y_shr     = y >>> idx;
        if (!z[XW-1]) begin
            x_nxt = x - y_shr;
            y_nxt = y + x_shr;
            z_nxt = z - atan_i;
        end else begin
            x_nxt = x + y_shr;
            y_nxt = y - x_shr;
            z_nxt = z + atan_i;
        end
        cos_sat = sat(x[W-1:0]);
        sin_sat = sat(y[W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            angle_q   <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            idx       <= '0;
            negate    <= 1'b0;
            range_err <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sin_out   <= '0;
            cos_out   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // The done cycle is still IDLE; a start there must not be taken.
                    if (start && !done) begin
                        angle_q <= angle;
                        busy    <= 1'b1;
                        state   <= StLoad;
                    end
                end
                StLoad: begin
                    idx <= '0;
                    if (angle_ext > PiVal || angle_ext < -PiVal) begin
                        range_err <= 1'b1;
                        negate    <= 1'b0;
                        x         <= '0;
                        y         <= '0;
                        z         <= '0;
                        state     <= StOut;
                    end else begin
                        range_err <= 1'b0;
                        x         <= KVal;
                        y         <= '0;
                        if (angle_ext > PiHalf) begin
                            z      <= angle_ext - PiVal;
                            negate <= 1'b1;
                        end else if (angle_ext < -PiHalf) begin
                            z      <= angle_ext + PiVal;
                            negate <= 1'b1;
                        end else begin
                            z      <= angle_ext;
                            negate <= 1'b0;
                        end
                        state <= StRot;
                    end
                end
                StRot: begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    z   <= z_nxt;
                    idx <= idx + IW'(1);
                    if (idx == LastIdx) begin
                        state <= StOut;
                    end
                end
                StOut: begin
                    err <= range_err;
                    if (range_err) begin
                        sin_out <= '0;
                        cos_out <= '0;
                    end else begin
                        sin_out <= negate ? -sin_sat : sin_sat;
                        cos_out <= negate ? -cos_sat : cos_sat;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos: the driver queues expected results, a monitor
// compares them whenever done is presented.
module tb_cordic_sincos;

    typedef struct {
        string       name;
        logic [31:0] s;
        logic [31:0] c;
        logic        e;
        int          tol;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] angle;
    logic        busy, done, err;
    logic [31:0] sin_out, cos_out;

    exp_t exp_q[$];
    chk_t chk_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    cordic_sincos #(
        .W   (32),
        .FRAC(16),
        .ITER(16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .angle  (angle),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .sin_out(sin_out),
        .cos_out(cos_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int absdiff(input logic [31:0] a, input logic [31:0] b);
        int d;
        d = int'(a) - int'(b);
        return (d < 0) ? -d : d;
    endfunction

    // Comparison tasks: called only from the monitor process.
    task automatic cmp_eq(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", n, act, req);
        end
    endtask

    task automatic cmp_tol(input string n, input logic [31:0] act, input logic [31:0] req,
                           input int tol);
        checks++;
        if ((^act === 1'bx) || absdiff(act, req) > tol) begin
            errors++;
            $display("FAIL %s: got %h, want %h +/- %0d", n, act, req, tol);
        end
    endtask

    task automatic cmp_bound(input string n, input logic [31:0] act);
        checks++;
        if (absdiff(act, 32'h0) > 32'h0001_0000) begin
            errors++;
            $display("FAIL %s: got %h, want magnitude <= 00010000", n, act);
        end
    endtask

    // Monitor: drains queued direct checks and scores every done pulse.
    initial begin
        exp_t e;
        chk_t c;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                cmp_eq(c.name, c.act, c.req);
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 sin=%h cos=%h, want no done",
                             sin_out, cos_out);
                end else begin
                    e = exp_q.pop_front();
                    cmp_tol({e.name, "_sin"}, sin_out, e.s, e.tol);
                    cmp_tol({e.name, "_cos"}, cos_out, e.c, e.tol);
                    cmp_eq({e.name, "_err"}, {31'b0, err}, {31'b0, e.e});
                    cmp_eq({e.name, "_latency"}, cyc - e.acc, e.lat);
                    cmp_bound({e.name, "_sin_bound"}, sin_out);
                    cmp_bound({e.name, "_cos_bound"}, cos_out);
                end
            end
        end
    end

    task automatic push_chk(input string n, input logic [31:0] act, input logic [31:0] req);
        chk_t c;
        c.name = n;
        c.act  = act;
        c.req  = req;
        chk_q.push_back(c);
    endtask

    task automatic push_exp(input string n, input logic [31:0] s, input logic [31:0] c,
                            input logic e, input int tol, input int lat);
        exp_t x;
        x.name = n;
        x.s    = s;
        x.c    = c;
        x.e    = e;
        x.tol  = tol;
        x.lat  = lat;
        x.acc  = cyc;
        exp_q.push_back(x);
    endtask

    task automatic issue(input logic [31:0] a);
        @(negedge clk);
        start = 1'b1;
        angle = a;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string n, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done === 1'b1) return;
        end
        push_chk({n, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run(input string n, input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] c, input logic e);
        issue(a);
        if (e) push_exp(n, s, c, e, 0, 2);
        else   push_exp(n, s, c, e, 4, 18);
        wait_done(n, 40);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        angle = '0;
        repeat (2) @(negedge clk);
        push_chk("reset_busy", {31'b0, busy}, 32'd0);
        push_chk("reset_done", {31'b0, done}, 32'd0);
        push_chk("reset_err", {31'b0, err}, 32'd0);
        push_chk("reset_sin", sin_out, 32'd0);
        push_chk("reset_cos", cos_out, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run("zero",   32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 1'b0);
        run("pi6",    32'h0000_860A, 32'h0000_8000, 32'h0000_DDB4, 1'b0);
        run("pi2",    32'h0001_921F, 32'h0001_0000, 32'h0000_0000, 1'b0);
        run("mpi2",   32'hFFFE_6DE1, 32'hFFFF_0000, 32'h0000_0000, 1'b0);
        run("pi",     32'h0003_243F, 32'h0000_0000, 32'hFFFF_0000, 1'b0);
        run("one",    32'h0001_0000, 32'h0000_D76A, 32'h0000_8A51, 1'b0);
        run("m2",     32'hFFFE_0000, 32'hFFFF_1738, 32'hFFFF_9577, 1'b0);
        run("oor_p4", 32'h0004_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        @(negedge clk);
        push_chk("err_held", {31'b0, err}, 32'd1);
        run("oor_mpi", 32'hFFFC_DBC0, 32'h0000_0000, 32'h0000_0000, 1'b1);
        run("mpi",     32'hFFFC_DBC1, 32'h0000_0000, 32'hFFFF_0000, 1'b0);

        // Starts during a run are ignored and the first angle wins.
        issue(32'h0000_860A);
        push_exp("busy_run", 32'h0000_8000, 32'h0000_DDB4, 1'b0, 4, 18);
        repeat (4) @(negedge clk);
        start = 1'b1;
        angle = 32'h0000_0000;
        push_chk("busy_at_5", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        angle = 32'h0004_0000;
        push_chk("busy_at_10", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_run", 40);

        // Start held through the done cycle: first edge ignored, second accepted.
        start = 1'b1;
        angle = 32'h0000_0000;
        @(posedge clk);
        #1;
        push_chk("done_cycle_ignored", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp("after_done", 32'h0000_0000, 32'h0001_0000, 1'b0, 4, 18);
        push_chk("after_done_busy", {31'b0, busy}, 32'd1);
        wait_done("after_done", 40);

        // Reset in the middle of a run: everything clears, no done afterwards.
        issue(32'h0001_921F);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        push_chk("midrst_busy", {31'b0, busy}, 32'd0);
        push_chk("midrst_done", {31'b0, done}, 32'd0);
        push_chk("midrst_sin", sin_out, 32'd0);
        push_chk("midrst_cos", cos_out, 32'd0);
        push_chk("midrst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        push_chk("midrst_idle", {31'b0, busy}, 32'd0);
        run("post_rst", 32'h0000_860A, 32'h0000_8000, 32'h0000_DDB4, 1'b0);

        repeat (3) @(negedge clk);
        push_chk("scoreboard_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
